// File: rtl/mult_booth_datapath_if.sv
// ============================================================================
// Module : mult_booth_datapath_if
// Brief  : Control/operand/result bundle between Booth control and datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_booth_datapath_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             reg_clr;
    logic             reg_ena;
    logic [1:0]       sla_ena;
    logic             adder_opcode;
    logic [1:0]       l2;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             result_valid;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        output reg_clr, reg_ena, sla_ena, adder_opcode,
        input  l2, data_result, data_exception, result_valid
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        input  reg_clr, reg_ena, sla_ena, adder_opcode,
        output l2, data_result, data_exception, result_valid
    );
endinterface

`default_nettype wire

// File: rtl/mult_booth_datapath.sv
// ============================================================================
// Module : mult_booth_datapath
// Brief  : Radix-4 Booth multiplier datapath: multiplicand, product register,
//          step counter, signed result and overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_booth_datapath #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 5
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    mult_booth_datapath_if.slave  bus
);
    localparam logic [STEP_W-1:0] c_STEPS = STEP_W'(WIDTH / 2);

    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_p;
    logic [STEP_W-1:0]  r_step;
    logic               r_valid;
    logic               r_armed;

    logic               w_load;
    logic               w_step;
    logic [WIDTH+1:0]   w_hi;
    logic [WIDTH+1:0]   w_mult;
    logic [WIDTH+1:0]   w_acc;

    assign w_load = bus.ctrl_MULT | bus.reg_clr;
    // r_armed keeps a reset-abandoned operation from stepping until a fresh load.
    assign w_step = bus.reg_ena & r_armed & (r_step != c_STEPS);

    assign w_hi = {{2{r_p[2*WIDTH-1]}}, r_p[2*WIDTH-1:WIDTH]};

    always_comb begin
        w_mult = '0;
        case (bus.sla_ena)
            2'b01:   w_mult = {{2{r_m[WIDTH-1]}}, r_m};
            2'b10:   w_mult = {r_m[WIDTH-1], r_m, 1'b0};
            default: w_mult = '0;
        endcase
    end

    assign w_acc = bus.adder_opcode ? (w_hi - w_mult) : (w_hi + w_mult);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m     <= '0;
            r_p     <= '0;
            r_step  <= '0;
            r_valid <= 1'b0;
            r_armed <= 1'b0;
        end else if (w_load) begin
            r_m     <= bus.data_operandA;
            r_p     <= {{WIDTH{1'b0}}, bus.data_operandB};
            r_step  <= '0;
            r_valid <= 1'b0;
            r_armed <= 1'b1;
        end else if (w_step) begin
            // Arithmetic shift right by 2 of {acc, P_lo}; dropped MSBs are sign copies.
            r_p    <= {w_acc, r_p[WIDTH-1:2]};
            r_step <= r_step + STEP_W'(1);
            if (r_step == c_STEPS - STEP_W'(1)) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.l2             = r_p[1:0];
    assign bus.data_result    = r_p[WIDTH-1:0];
    assign bus.result_valid   = r_valid;
    assign bus.data_exception = r_valid & (r_p[2*WIDTH-1:WIDTH] != {WIDTH{r_p[WIDTH-1]}});

endmodule

`default_nettype wire

// File: tb/tb_mult_booth_datapath.sv
// ============================================================================
// Module : tb_mult_booth_datapath
// Brief  : Self-checking bench for mult_booth_datapath against a signed-product model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_booth_datapath;
    localparam int W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    mult_booth_datapath_if #(.WIDTH(W)) bus ();

    mult_booth_datapath #(.WIDTH(W), .STEP_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Booth digit for pair i of b: returns {subtract, multiple select}.
    function automatic logic [2:0] booth_ctl(input logic [31:0] b, input int i);
        int v;
        v = 0;
        if (b[2*i+1]) v = v - 2;
        if (b[2*i])   v = v + 1;
        if (i > 0 && b[2*i-1]) v = v + 1;
        case (v)
            -2:      return 3'b1_10;
            -1:      return 3'b1_01;
            1:       return 3'b0_01;
            2:       return 3'b0_10;
            default: return 3'b0_00;
        endcase
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return 64'(sa * sb);
    endfunction

    task automatic idle_inputs();
        bus.ctrl_MULT     = 1'b0;
        bus.reg_clr       = 1'b0;
        bus.reg_ena       = 1'b0;
        bus.sla_ena       = 2'b00;
        bus.adder_opcode  = 1'b0;
    endtask

    // Enters and leaves just after a falling edge.
    task automatic load(input logic [31:0] a, input logic [31:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        bus.reg_clr       = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (bus.l2 !== b[1:0] || bus.result_valid !== 1'b0)
            $display("FAIL load_state: l2=%b valid=%b, want l2=%b valid=0", bus.l2, bus.result_valid, b[1:0]);
        else n_pass++;
    endtask

    task automatic do_steps(input logic [31:0] b, input int first, input int last,
                            input int stall_at, input int stall_len);
        logic [31:0] held_res;
        logic [1:0]  held_l2;
        logic [2:0]  c;
        for (int i = first; i <= last; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    held_res         = bus.data_result;
                    held_l2          = bus.l2;
                    bus.reg_ena      = 1'b0;
                    bus.sla_ena      = 2'($urandom);
                    bus.adder_opcode = 1'($urandom);
                    @(negedge clk);
                    n_checks++;
                    if (bus.data_result !== held_res || bus.l2 !== held_l2 || bus.result_valid !== 1'b0)
                        $display("FAIL stall_freeze step %0d: res=%h l2=%b valid=%b, want res=%h l2=%b valid=0",
                                 i, bus.data_result, bus.l2, bus.result_valid, held_res, held_l2);
                    else n_pass++;
                end
            end
            c                = booth_ctl(b, i);
            bus.adder_opcode = c[2];
            bus.sla_ena      = c[1:0];
            bus.reg_ena      = 1'b1;
            @(negedge clk);
            idle_inputs();
            n_checks++;
            if (bus.result_valid !== (i == 15))
                $display("FAIL valid_timing step %0d: valid=%b, want %b", i, bus.result_valid, (i == 15));
            else n_pass++;
            if (i < 15) begin
                n_checks++;
                if (bus.l2 !== b[2*i+3 -: 2])
                    $display("FAIL l2_recode step %0d: l2=%b, want %b", i, bus.l2, b[2*i+3 -: 2]);
                else n_pass++;
            end
        end
    endtask

    task automatic check_result(input string nm, input logic [31:0] res, input logic exc);
        n_checks++;
        if (bus.data_result !== res || bus.data_exception !== exc || bus.result_valid !== 1'b1)
            $display("FAIL %s: res=%h exc=%b valid=%b, want res=%h exc=%b valid=1",
                     nm, bus.data_result, bus.data_exception, bus.result_valid, res, exc);
        else n_pass++;
    endtask

    task automatic check_model(input string nm, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        p   = ref_prod(a, b);
        ovf = (p[63:32] != {32{p[31]}});
        check_result(nm, p[31:0], ovf);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.data_result !== 32'h0 || bus.data_exception !== 1'b0 ||
            bus.result_valid !== 1'b0 || bus.l2 !== 2'b00)
            $display("FAIL reset_state: res=%h exc=%b valid=%b l2=%b, want all zero",
                     bus.data_result, bus.data_exception, bus.result_valid, bus.l2);
        else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] av [4] = '{32'd3, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] bv [4] = '{32'd5, 32'd6,        32'd2,        32'hFFFF_FFFF};
        logic [31:0] rv [4] = '{32'h0000_000F, 32'hFFFF_FFD6, 32'hFFFF_FFFE, 32'h8000_0000};
        logic        ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            load(av[k], bv[k]);
            do_steps(bv[k], 0, 15, -1, 0);
            check_result($sformatf("directed_%0d", k), rv[k], ev[k]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 4 == 1) a = 32'($signed(16'($urandom)));
            if (k % 4 == 2) b = {k[0], 31'($urandom_range(0, 3))};
            load(a, b);
            do_steps(b, 0, 15, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            check_model($sformatf("random_%0d", k), a, b);
        end
    endtask

    task automatic test_stall();
        load(32'h0001_0000, 32'h0001_0000);
        do_steps(32'h0001_0000, 0, 15, 6, 3);
        check_result("stall_2p32", 32'h0000_0000, 1'b1);
    endtask

    task automatic test_async_reset();
        load(32'd5, 32'd7);
        do_steps(32'd7, 0, 7, -1, 0);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.data_result !== 32'h0 || bus.data_exception !== 1'b0 ||
            bus.result_valid !== 1'b0 || bus.l2 !== 2'b00)
            $display("FAIL async_reset: res=%h exc=%b valid=%b l2=%b, want all zero",
                     bus.data_result, bus.data_exception, bus.result_valid, bus.l2);
        else n_pass++;
        @(negedge clk);
        resetn      = 1'b1;
        bus.reg_ena = 1'b1;
        bus.sla_ena = 2'b01;
        repeat (20) @(negedge clk);
        idle_inputs();
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.data_result !== 32'h0)
            $display("FAIL no_step_after_reset: valid=%b res=%h, want valid=0 res=0",
                     bus.result_valid, bus.data_result);
        else n_pass++;
        load(32'd2, 32'd2);
        do_steps(32'd2, 0, 15, -1, 0);
        check_result("after_reset_2x2", 32'd4, 1'b0);
    endtask

    task automatic test_restart();
        load(32'h1234_5678, 32'h0F0F_0F0F);
        do_steps(32'h0F0F_0F0F, 0, 4, -1, 0);
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'hFFFF_FFFF;
        bus.ctrl_MULT     = 1'b1;
        bus.reg_ena       = 1'b1;
        bus.sla_ena       = 2'b10;
        bus.adder_opcode  = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (bus.l2 !== 2'b11 || bus.result_valid !== 1'b0 || bus.data_result !== 32'hFFFF_FFFF)
            $display("FAIL restart_load: l2=%b valid=%b res=%h, want l2=11 valid=0 res=ffffffff",
                     bus.l2, bus.result_valid, bus.data_result);
        else n_pass++;
        do_steps(32'hFFFF_FFFF, 0, 15, -1, 0);
        check_result("restart_9xm1", 32'hFFFF_FFF7, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.reg_ena      = 1'b1;
            bus.sla_ena      = 2'($urandom_range(1, 2));
            bus.adder_opcode = 1'($urandom);
            @(negedge clk);
        end
        idle_inputs();
        check_result("hold_after_done", 32'hFFFF_FFF7, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_async_reset();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_booth_datapath.md
Name: mult_booth_datapath

Overview:
Radix-4 Booth multiplier datapath, directly downstream of the multiplier control FSM.
- Consumes per-cycle control signals: sla_ena, adder_opcode, reg_clr, reg_ena.
- Returns the two lowest product-register bits (l2) back to the control for recoding.
- Holds the multiplicand and the 64-bit product register.
- Counts completed Booth steps and produces the 32-bit signed result with an overflow exception flag.

Parameters:
WIDTH, 32, operand and result width (even; step count = WIDTH/2)
STEP_W, 5, width of internal step counter (must hold WIDTH/2)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
ctrl_MULT  input  1  start pulse: latch operands, restart operation
data_operandA  input  WIDTH  multiplicand, signed, sampled when ctrl_MULT=1
data_operandB  input  WIDTH  multiplier, signed, sampled when ctrl_MULT=1
reg_clr  input  1  from control: clear/load product register (high with ctrl_MULT)
reg_ena  input  1  from control: perform one Booth step this cycle
sla_ena  input  2  from control: 00 add 0, 01 use 1x multiplicand, 10 use 2x multiplicand, 11 treated as 00
adder_opcode  input  1  from control: 0 add, 1 subtract selected multiple
l2  output  2  product register bits [1:0] to control
data_result  output  WIDTH  low WIDTH bits of product
data_exception  output  1  signed overflow of WIDTH-bit result
result_valid  output  1  all WIDTH/2 steps complete

Behaviour:
Reset (resetn=0, asynchronous, immediate):
- Multiplicand register M, product register P[2*WIDTH-1:0] and step counter all clear to 0.
- Therefore data_result=0, data_exception=0, result_valid=0, l2=00.
- Reset mid-operation abandons the operation. No step occurs until the next ctrl_MULT.

Load (rising edge with ctrl_MULT=1 or reg_clr=1):
- M <= data_operandA.
- P <= {WIDTH'b0, data_operandB}.
- step <= 0, result_valid <= 0.
- Load has priority over reg_ena in the same cycle.
- ctrl_MULT while an operation is busy restarts the operation with the new operands.

Step (rising edge with reg_ena=1, no load, step < WIDTH/2):
- hi = P[2W-1:W], sign-extended to W+2 bits.
- mult = 0 / sext(M) / sext(M)<<1, selected by sla_ena.
- acc = adder_opcode ? hi - mult : hi + mult, in W+2 bits with no truncation.
- {acc, P[W-1:0]} is arithmetically shifted right by 2. P <= low 2W bits of the shifted value.
- step <= step + 1.
- When step reaches WIDTH/2, result_valid <= 1.

After completion:
- reg_ena is ignored while step == WIDTH/2. The counter saturates and does not wrap.
- P and result_valid hold until the next load or reset.
- reg_ena=0 leaves all state unchanged (stall).

Outputs:
- l2 = P[1:0], combinational from the register. Valid the cycle after load for the first recoding.
- data_result = P[W-1:0], continuously driven. Meaningful only when result_valid=1.
- data_exception = result_valid & (P[2W-1:W] != {W{P[W-1]}}), i.e. the upper half is not the sign extension of the result. It is 0 whenever result_valid=0.

Latency and edge cases:
- Latency: result_valid asserts WIDTH/2 enabled steps after load; 16 cycles for W=32 with reg_ena held high.
- The lowest recoding bit (the implicit P[-1]) is owned by the control block and is not stored here.

Test Plan:
- Operands 3 × 5, bench drives Booth controls from a reference recoder, reg_ena high -> result_valid after 16 steps, data_result=0x0000000F, data_exception=0.
- Operands -7 × 6 -> data_result=0xFFFFFFD6 (-42), data_exception=0. Checks the subtract path and the 2x multiple.
- Operands 0x7FFFFFFF × 2 -> data_result=0xFFFFFFFE, data_exception=1. Also 0x80000000 × 0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- Stall reg_ena low for 3 cycles mid-operation (0x00010000 × 0x00010000) -> P frozen during the stall, final data_exception=1 (product 2^32), result_valid delayed by 3 cycles.
- resetn pulsed low asynchronously between clock edges after step 8 -> all outputs 0 immediately, no steps until ctrl_MULT. Then 2 × 2 -> data_result=4.
- ctrl_MULT reasserted at step 5 with 9 × -1 -> old operation discarded, step=0, final data_result=0xFFFFFFF7. Extra reg_ena after completion -> result held.
